trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 137 +++++++++++++
 tb/tb_trap_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - prioritised interrupt/trap redirect with EPC stack for a 3-source core
// Build option: define TRAP_NEST_EN for a 3-deep nesting stack with preemption; otherwise 1 deep.
module trap_ctrl #(
  parameter logic [31:0] VEC0 = 32'h0000_0400,
  parameter logic [31:0] VEC1 = 32'h0000_0500,
  parameter logic [31:0] VEC2 = 32'h0000_0600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] pc_next,
  input  logic        ecall,
  input  logic        uret,
  input  logic [2:0]  ir_req,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic [1:0]  cur_level,
  output logic [2:0]  ir_pending,
  output logic        halt
);

`ifdef TRAP_NEST_EN
  localparam int   DEPTH = 3;
  localparam logic NEST  = 1'b1;
`else
  localparam int   DEPTH = 1;
  localparam logic NEST  = 1'b0;
`endif
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]  ir_q;
  logic [2:0]  pend_q, pend_d;
  logic [1:0]  lvl_q, lvl_d;
  logic [1:0]  sp_q, sp_d;
  logic        halt_q, halt_d;
  logic [31:0] epc_q  [DEPTH];
  logic [1:0]  elvl_q [DEPTH];

  logic            cand_ok;
  logic [1:0]      cand_n;
  logic            stack_full;
  logic            commit_ok;
  logic            do_take;
  logic            do_ret;
  logic [IDXW-1:0] top_idx;
  logic [IDXW-1:0] push_idx;
  logic [31:0]     vec_addr;
  logic [2:0]      ir_edge;

  // Highest pending source whose priority beats the level in service.
  always_comb begin
    cand_ok = 1'b0;
    cand_n  = 2'd0;
    for (int n = 2; n >= 0; n--) begin
      if (!cand_ok && pend_q[n] &&
          (NEST ? ((3'(n) + 3'd1) > {1'b0, lvl_q}) : (lvl_q == 2'd0))) begin
        cand_ok = 1'b1;
        cand_n  = 2'(n);
      end
    end
  end

  assign stack_full = (sp_q == 2'(DEPTH));
  assign commit_ok  = instr_valid & ~halt_q & ~ecall;
  assign do_ret     = commit_ok & uret & (sp_q != 2'd0);
  assign do_take    = commit_ok & ~uret & cand_ok & ~stack_full;
  assign top_idx    = IDXW'(sp_q - 2'd1);
  assign push_idx   = IDXW'(sp_q);
  assign ir_edge    = ir_req & ~ir_q;

  always_comb begin
    case (cand_n)
      2'd2:    vec_addr = VEC2;
      2'd1:    vec_addr = VEC1;
      default: vec_addr = VEC0;
    endcase
  end

  always_comb begin
    pc_sel    = do_take | do_ret;
    pc_target = 32'd0;
    if (do_ret) begin
      pc_target = epc_q[top_idx];
    end else if (do_take) begin
      pc_target = vec_addr;
    end
  end

  // A fresh edge on the source being taken wins over its clear.
  always_comb begin
    pend_d = pend_q;
    lvl_d  = lvl_q;
    sp_d   = sp_q;
    halt_d = halt_q;
    if (instr_valid && ecall) begin
      halt_d = 1'b1;
    end
    if (do_take) begin
      pend_d[cand_n] = 1'b0;
      lvl_d          = cand_n + 2'd1;
      sp_d           = sp_q + 2'd1;
    end
    if (do_ret) begin
      lvl_d = elvl_q[top_idx];
      sp_d  = sp_q - 2'd1;
    end
    pend_d = pend_d | ir_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q   <= 3'd0;
      pend_q <= 3'd0;
      lvl_q  <= 2'd0;
      sp_q   <= 2'd0;
      halt_q <= 1'b0;
    end else begin
      ir_q   <= ir_req;
      pend_q <= pend_d;
      lvl_q  <= lvl_d;
      sp_q   <= sp_d;
      halt_q <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_take) begin
      epc_q[push_idx]  <= pc_next;
      elvl_q[push_idx] <= lvl_q;
    end
  end

  assign cur_level  = lvl_q;
  assign ir_pending = pend_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed scenarios plus random traffic against a queue-based trap model
// Follows the DUT build option TRAP_NEST_EN.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] pc_next;
  logic        ecall;
  logic        uret;
  logic [2:0]  ir_req;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic [1:0]  cur_level;
  logic [2:0]  ir_pending;
  logic        halt;

  trap_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .pc_next    (pc_next),
    .ecall      (ecall),
    .uret       (uret),
    .ir_req     (ir_req),
    .pc_sel     (pc_sel),
    .pc_target  (pc_target),
    .cur_level  (cur_level),
    .ir_pending (ir_pending),
    .halt       (halt)
  );

  always #5 clk = ~clk;

`ifdef TRAP_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: pending set, previous request sample, level, halt, EPC stack.
  bit [2:0]    m_pend;
  bit [2:0]    m_prev;
  int          m_lvl;
  bit          m_halt;
  logic [31:0] m_epc [$];
  int          m_elvl [$];

  logic        last_sel;
  logic [31:0] last_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_cand();
    for (int n = 2; n >= 0; n--) begin
      if (m_pend[n] && (NEST ? (n + 1 > m_lvl) : (m_lvl == 0))) return n;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_vec(input int n);
    return 32'h0000_0400 + 32'(n) * 32'h100;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_level"},   {30'd0, cur_level}, 32'(m_lvl));
    chk({tag, "_pending"}, {29'd0, ir_pending}, {29'd0, m_pend});
    chk({tag, "_halt"},    {31'd0, halt},      {31'd0, m_halt});
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; ecall = 1'b0; uret = 1'b0;
    ir_req = 3'd0; pc_next = 32'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    m_pend = '0; m_prev = '0; m_lvl = 0; m_halt = 1'b0;
    m_epc.delete(); m_elvl.delete();
    @(negedge clk);
    check_state("reset");
  endtask

  task automatic step(input bit v, input logic [31:0] pcn, input bit ec, input bit ur,
                      input logic [2:0] ir);
    int          c;
    bit          take, ret;
    logic [31:0] tgt;
    bit [2:0]    edges;
    instr_valid = v; pc_next = pcn; ecall = ec; uret = ur; ir_req = ir;
    #1;
    c    = m_cand();
    ret  = v && !m_halt && !ec && ur && (m_epc.size() > 0);
    take = v && !m_halt && !ec && !ur && (c >= 0);
    tgt  = ret ? m_epc[$] : (take ? m_vec(c) : 32'd0);
    last_sel = pc_sel;
    last_tgt = pc_target;
    chk("pc_sel",    {31'd0, pc_sel}, {31'd0, take | ret});
    chk("pc_target", pc_target, tgt);
    @(posedge clk);
    edges  = ir & ~m_prev;
    m_prev = ir;
    if (v && ec) m_halt = 1'b1;
    if (ret) begin
      m_lvl = m_elvl.pop_back();
      void'(m_epc.pop_back());
    end
    if (take) begin
      m_epc.push_back(pcn);
      m_elvl.push_back(m_lvl);
      m_lvl = c + 1;
      m_pend[c] = 1'b0;
    end
    m_pend = m_pend | edges;
    @(negedge clk);
    check_state("step");
    instr_valid = 1'b0; ecall = 1'b0; uret = 1'b0;
  endtask

  initial begin
    do_reset();

    // Basic take and return on IR0
    step(0, 32'h0, 0, 0, 3'b001);
    chk("s29_pend", {29'd0, ir_pending}, 32'h1);
    step(1, 32'h40, 0, 0, 3'b001);
    chk("s29_take_tgt", last_tgt, 32'h400);
    chk("s29_take_lvl", {30'd0, cur_level}, 32'd1);
    step(1, 32'h44, 0, 1, 3'b000);
    chk("s29_ret_tgt", last_tgt, 32'h40);
    chk("s29_ret_lvl", {30'd0, cur_level}, 32'd0);

    // IR2 arriving during IR0 service
    step(0, 32'h0, 0, 0, 3'b001);
    step(1, 32'h100, 0, 0, 3'b001);
    step(0, 32'h0, 0, 0, 3'b101);
    step(1, 32'h408, 0, 0, 3'b101);
`ifdef TRAP_NEST_EN
    chk("s30_tgt", last_tgt, 32'h600);
    chk("s30_lvl", {30'd0, cur_level}, 32'd3);
    step(1, 32'h604, 0, 1, 3'b101);
    chk("s30_ret_tgt", last_tgt, 32'h408);
    chk("s30_ret_lvl", {30'd0, cur_level}, 32'd1);
    step(1, 32'h40c, 0, 1, 3'b000);
`else
    chk("s31_nosel", {31'd0, last_sel}, 32'd0);
    chk("s31_pend", {29'd0, ir_pending}, 32'h4);
    step(1, 32'h40c, 0, 1, 3'b101);
    chk("s31_ret_tgt", last_tgt, 32'h100);
    step(1, 32'h104, 0, 0, 3'b000);
    chk("s31_take_tgt", last_tgt, 32'h600);
    chk("s31_take_lvl", {30'd0, cur_level}, 32'd3);
    step(1, 32'h604, 0, 1, 3'b000);
`endif

    // Simultaneous IR1 and IR2 edges
    step(0, 32'h0, 0, 0, 3'b000);
    step(0, 32'h0, 0, 0, 3'b110);
    step(1, 32'h200, 0, 0, 3'b110);
    chk("s32_tgt", last_tgt, 32'h600);
    chk("s32_pend", {29'd0, ir_pending}, 32'h2);
    step(1, 32'h604, 0, 1, 3'b000);
    chk("s32_ret_tgt", last_tgt, 32'h200);
    step(1, 32'h200, 0, 0, 3'b000);
    chk("s32_ir1_tgt", last_tgt, 32'h500);
    step(1, 32'h504, 0, 1, 3'b000);

    // New IR0 edge on the very take of IR0 keeps it pending
    step(0, 32'h0, 0, 0, 3'b001);
    step(0, 32'h0, 0, 0, 3'b000);
    step(1, 32'h300, 0, 0, 3'b001);
    chk("s23_tgt", last_tgt, 32'h400);
    chk("s23_pend", {29'd0, ir_pending}, 32'h1);
    step(1, 32'h404, 0, 1, 3'b001);
    chk("s23_ret_tgt", last_tgt, 32'h300);

    // ecall beats a pending take and halts for good
    step(1, 32'h340, 1, 0, 3'b000);
    chk("s33_sel", {31'd0, last_sel}, 32'd0);
    chk("s33_halt", {31'd0, halt}, 32'd1);
    step(1, 32'h344, 0, 0, 3'b010);
    chk("s33_sel2", {31'd0, last_sel}, 32'd0);
    step(1, 32'h348, 0, 1, 3'b010);
    chk("s33_sel3", {31'd0, last_sel}, 32'd0);

    // uret with empty stack, then reset in the middle of IR1 service
    do_reset();
    step(1, 32'h80, 0, 1, 3'b000);
    chk("s34_sel", {31'd0, last_sel}, 32'd0);
    chk("s34_lvl", {30'd0, cur_level}, 32'd0);
    step(0, 32'h0, 0, 0, 3'b010);
    step(1, 32'h84, 0, 0, 3'b010);
    chk("s34_lvl2", {30'd0, cur_level}, 32'd2);
    step(0, 32'h0, 0, 0, 3'b110);
    do_reset();
    chk("s34_rst_lvl", {30'd0, cur_level}, 32'd0);
    chk("s34_rst_pend", {29'd0, ir_pending}, 32'd0);
    step(1, 32'h88, 0, 1, 3'b000);
    chk("s34_uret_noop", {31'd0, last_sel}, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3fff), 2'b00},
             ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
